// File: rtl/argmax_classifier.sv
// Argmax over one frame of NUM_CLASSES signed activations from an AXI4-Stream.
// Ports: ACLK/ARESET, start, s_* stream in, res_* result out, busy; ARGMAX_TLAST_CHECK_EN adds s_tlast/frame_err.
module argmax_classifier #(
  parameter int DATA_W      = 32,
  parameter int NUM_CLASSES = 10,
  parameter int IDX_W       = 4
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic              start,
  input  logic [DATA_W-1:0] s_tdata,
  input  logic              s_tvalid,
  output logic              s_tready,
`ifdef ARGMAX_TLAST_CHECK_EN
  input  logic              s_tlast,
  output logic              frame_err,
`endif
  output logic [IDX_W-1:0]  res_idx,
  output logic [DATA_W-1:0] res_val,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_RESULT
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  best_idx_q, best_idx_d;
  logic [DATA_W-1:0] best_val_q, best_val_d;
  logic [IDX_W-1:0]  res_idx_q, res_idx_d;
  logic [DATA_W-1:0] res_val_q, res_val_d;

  logic              take;
  logic              at_last;
  logic              frame_end;
  logic [IDX_W-1:0]  cand_idx;
  logic [DATA_W-1:0] cand_val;

  // Beat 0 always loads; later beats need a strictly greater value,
  // so ties keep the lower index.
  assign take     = (cnt_q == '0) ||
                    ($signed(s_tdata) > $signed(best_val_q));
  assign cand_idx = take ? cnt_q : best_idx_q;
  assign cand_val = take ? s_tdata : best_val_q;
  assign at_last  = (cnt_q == LAST_IDX);

`ifdef ARGMAX_TLAST_CHECK_EN
  logic err_q, err_d;
  logic tlast_bad;

  // Early tlast ends the frame with a partial max; a missing tlast on
  // the final beat only flags the error.
  assign frame_end = at_last || s_tlast;
  assign tlast_bad = (s_tlast != at_last);
  assign frame_err = err_q;
`else
  assign frame_end = at_last;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    best_idx_d = best_idx_q;
    best_val_d = best_val_q;
    res_idx_d  = res_idx_q;
    res_val_d  = res_val_q;
`ifdef ARGMAX_TLAST_CHECK_EN
    err_d      = err_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_COLLECT;
          cnt_d      = '0;
          best_idx_d = '0;
          best_val_d = '0;
`ifdef ARGMAX_TLAST_CHECK_EN
          err_d      = 1'b0;
`endif
        end
      end
      S_COLLECT: begin
        if (start) begin
          // Restart: the beat offered this cycle is dropped.
          cnt_d      = '0;
          best_idx_d = '0;
          best_val_d = '0;
`ifdef ARGMAX_TLAST_CHECK_EN
          err_d      = 1'b0;
`endif
        end else if (s_tvalid) begin
          cnt_d      = cnt_q + 1'b1;
          best_idx_d = cand_idx;
          best_val_d = cand_val;
`ifdef ARGMAX_TLAST_CHECK_EN
          if (tlast_bad) begin
            err_d = 1'b1;
          end
`endif
          if (frame_end) begin
            state_d   = S_RESULT;
            res_idx_d = cand_idx;
            res_val_d = cand_val;
          end
        end
      end
      S_RESULT: begin
        if (res_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      best_idx_q <= '0;
      best_val_q <= '0;
      res_idx_q  <= '0;
      res_val_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      best_idx_q <= best_idx_d;
      best_val_q <= best_val_d;
      res_idx_q  <= res_idx_d;
      res_val_q  <= res_val_d;
    end
  end

`ifdef ARGMAX_TLAST_CHECK_EN
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end
`endif

  assign s_tready  = (state_q == S_COLLECT);
  assign busy      = (state_q == S_COLLECT);
  assign res_valid = (state_q == S_RESULT);
  assign res_idx   = res_idx_q;
  assign res_val   = res_val_q;

endmodule

// File: tb/tb_argmax_classifier.sv
// Bench for argmax_classifier: frame-level model checked every cycle,
// plus literal expectations for the directed frames.
module tb_argmax_classifier;

  localparam int NC = 10;
  localparam int IW = 4;
`ifdef ARGMAX_TLAST_CHECK_EN
  localparam bit TLAST_EN = 1'b1;
`else
  localparam bit TLAST_EN = 1'b0;
`endif

  typedef logic [31:0] frame_t [NC];

  logic          ACLK = 1'b0;
  logic          ARESET = 1'b1;
  logic          start = 1'b0;
  logic [31:0]   s_tdata = '0;
  logic          s_tvalid = 1'b0;
  logic          s_tready;
  logic          s_tlast = 1'b0;
  logic          frame_err_w;
  logic [IW-1:0] res_idx;
  logic [31:0]   res_val;
  logic          res_valid;
  logic          res_ready = 1'b1;
  logic          busy;

  int compared = 0;
  int mismatched = 0;

  always #5 ACLK = ~ACLK;

  argmax_classifier #(
    .DATA_W(32),
    .NUM_CLASSES(NC),
    .IDX_W(IW)
  ) dut (
    .ACLK(ACLK),
    .ARESET(ARESET),
    .start(start),
    .s_tdata(s_tdata),
    .s_tvalid(s_tvalid),
    .s_tready(s_tready),
`ifdef ARGMAX_TLAST_CHECK_EN
    .s_tlast(s_tlast),
    .frame_err(frame_err_w),
`endif
    .res_idx(res_idx),
    .res_val(res_val),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .busy(busy)
  );

`ifndef ARGMAX_TLAST_CHECK_EN
  assign frame_err_w = 1'b0;
`endif

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Frame-level model: 0 idle, 1 collecting, 2 result pending.
  int          m_state = 0;
  logic [31:0] mq[$];
  logic [31:0] m_idx = '0;
  logic [31:0] m_val = '0;
  logic        m_err = 1'b0;
  bit          armed = 1'b0;

  function automatic int argmax_of();
    int b = 0;
    for (int i = 1; i < mq.size(); i++)
      if ($signed(mq[i]) > $signed(mq[b])) b = i;
    return b;
  endfunction

  always @(negedge ACLK) begin
    bit done;
    int b;
    if (armed) begin
      chk("busy", {31'b0, busy}, {31'b0, m_state == 1});
      chk("s_tready", {31'b0, s_tready}, {31'b0, m_state == 1});
      chk("res_valid", {31'b0, res_valid}, {31'b0, m_state == 2});
      chk("res_idx", {28'b0, res_idx}, m_idx);
      chk("res_val", res_val, m_val);
      chk("frame_err", {31'b0, frame_err_w}, {31'b0, TLAST_EN && m_err});
    end
    if (ARESET) begin
      m_state = 0;
      mq.delete();
      m_idx = '0;
      m_val = '0;
      m_err = 1'b0;
      armed = 1'b1;
    end else begin
      case (m_state)
        0: if (start) begin
          m_state = 1;
          mq.delete();
          m_err = 1'b0;
        end
        1: if (start) begin
          mq.delete();
          m_err = 1'b0;
        end else if (s_tvalid) begin
          mq.push_back(s_tdata);
          done = (mq.size() == NC);
          if (TLAST_EN && s_tlast && !done) begin
            done = 1'b1;
            m_err = 1'b1;
          end else if (TLAST_EN && !s_tlast && done) begin
            m_err = 1'b1;
          end
          if (done) begin
            b = argmax_of();
            m_idx = b;
            m_val = mq[b];
            m_state = 2;
          end
        end
        default: if (res_ready) m_state = 0;
      endcase
    end
  end

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  // Start pulse (with a would-be winner offered to prove it is dropped),
  // n beats with optional gaps, result held for 'hold' cycles.
  task automatic run_frame(input frame_t v, input int n, input int max_gap,
                           input int hold, input bit b2b,
                           input logic [31:0] exp_idx,
                           input logic [31:0] exp_val, input string tag);
    bit seen = 1'b0;
    start = 1'b1;
    s_tvalid = 1'b1;
    s_tdata = 32'h7fff_ffff;
    res_ready = (hold == 0);
    tick();
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (max_gap > 0) begin
        repeat ($urandom_range(0, max_gap)) begin
          s_tvalid = 1'b0;
          s_tdata = $urandom;
          tick();
        end
      end
      s_tvalid = 1'b1;
      s_tdata = v[i];
      s_tlast = (i == n - 1);
      tick();
    end
    s_tlast = 1'b0;
    s_tvalid = (hold > 0);
    s_tdata = 32'h7fff_fffe;
    repeat (hold) tick();
    res_ready = 1'b1;
    start = b2b;
    for (int k = 0; k < 8 && !seen; k++) begin
      if (res_valid) seen = 1'b1;
      tick();
    end
    s_tvalid = 1'b0;
    if (!seen) chk({tag, "_res_timeout"}, 32'd0, 32'd1);
    chk({tag, "_idx"}, {28'b0, res_idx}, exp_idx);
    chk({tag, "_val"}, res_val, exp_val);
  endtask

  frame_t f;

  initial begin
    tick();
    tick();
    ARESET = 1'b0;
    tick();

    // T2 basic
    f = '{5, -3, 12, 7, 0, 1, 2, 3, 4, 11};
    run_frame(f, NC, 0, 0, 1'b0, 2, 12, "t2");

    // T1 reset mid-frame
    start = 1'b1;
    tick();
    start = 1'b0;
    s_tvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_tdata = 32'd50 + i;
      tick();
    end
    ARESET = 1'b1;
    repeat (3) tick();
    ARESET = 1'b0;
    s_tvalid = 1'b0;
    chk("t1_res_valid", {31'b0, res_valid}, 32'd0);
    chk("t1_s_tready", {31'b0, s_tready}, 32'd0);
    chk("t1_res_idx", {28'b0, res_idx}, 32'd0);
    chk("t1_res_val", res_val, 32'd0);
    repeat (3) tick();

    // T3 ties and extremes
    f = '{-1, -1, -1, -1, 100, -1, -1, 100, -1, -1};
    run_frame(f, NC, 0, 0, 1'b0, 4, 100, "t3a");
    for (int i = 0; i < NC; i++) f[i] = 32'h8000_0000;
    run_frame(f, NC, 0, 0, 1'b0, 0, 32'h8000_0000, "t3b");
    f = '{32'h8000_0000, 32'h7fff_ffff, 0, 0, 0, 0, 0, 0, 0, 0};
    run_frame(f, NC, 0, 0, 1'b0, 1, 32'h7fff_ffff, "t3c");

    // T4 backpressure with gaps; winner at the final index
    f = '{-50, -20, -20, -7, -100, -7, -30, -8, -9, -1};
    run_frame(f, NC, 3, 20, 1'b1, 9, 32'hffff_ffff, "t4");

    // Back-to-back start, then T5 restart after 4 beats
    s_tvalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_tdata = 32'd1000 + i;
      tick();
    end
    f = '{3, 9, 2, 9, 1, 0, 8, 7, 6, 5};
    run_frame(f, NC, 1, 0, 1'b0, 1, 9, "t5");
    start = 1'b0;
    repeat (2) tick();

`ifdef ARGMAX_TLAST_CHECK_EN
    // T6 early tlast on beat 5, then a clean frame
    f = '{1, 2, 3, 4, 5, 6, 99, 0, 0, 0};
    run_frame(f, 6, 0, 0, 1'b0, 5, 6, "t6a");
    chk("t6_err_set", {31'b0, frame_err_w}, 32'd1);
    f = '{0, 0, 0, 0, 0, 0, 0, 0, 8, 0};
    run_frame(f, NC, 0, 0, 1'b0, 8, 8, "t6b");
    chk("t6_err_clr", {31'b0, frame_err_w}, 32'd0);
`endif

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
